clk_switch_ctrl: RTL and testbench

Synchronous sequencer that generates the clock-gating enables and the clock-mux select consumed by the lab1 clock tree. It runs on the always-on oscillator clock and turns a single-source switch request into a glitch-safe sequence: gate the system clock off, wait, flip the mux, wait, and re-enable. Its outputs connect directly to `pll_cg_en`, `osc_cg_en`, `sys_cg_en` and `clkmux_sel` of the clock tree.

---
 rtl/clk_switch_pkg.sv | 16 +
 rtl/clk_sw_dly_cnt.sv | 30 +++
 rtl/clk_switch_ctrl.sv | 170 +++++++++++++++++
 tb/tb_clk_switch_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/clk_switch_pkg.sv
// Shared types and constants for the clock-switch controller.
package clk_switch_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OFF_WAIT = 2'd1,
        SW_WAIT  = 2'd2,
        DONE     = 2'd3
    } clk_sw_state_t;

    localparam logic SEL_PLL = 1'b0;
    localparam logic SEL_OSC = 1'b1;

    localparam int CNT_W = 8;

endpackage

// File: rtl/clk_sw_dly_cnt.sv
// Loadable down-counter with a zero flag. It is shared by the gate-off wait and
// the post-flip wait. A load takes priority over a decrement. The counter stops
// at zero rather than wrapping.
module clk_sw_dly_cnt
    import clk_switch_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    // Count register: synchronous clear, load, or decrement toward zero.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/clk_switch_ctrl.sv
// Glitch-safe clock-switch sequencer. On a switch request it gates the system
// clock off, waits GATE_CYC cycles, flips the mux, waits SW_CYC cycles, and
// then re-enables the system clock.
//
// Optional feature macro: CLK_SW_AUTO_GATE_EN. When it is defined, the branch
// gate of the source that was switched away from is turned off at the end of
// the sequence.
//
// Handshake: a request is accepted on a rising edge where req_valid && req_ready.
// req_ready is high only in IDLE. req_valid is ignored while busy, and requests
// are never queued. done pulses for one cycle when a request completes.
module clk_switch_ctrl
    import clk_switch_pkg::*;
#(
    parameter int GATE_CYC = 4,
    parameter int SW_CYC   = 8
) (
    input  logic       osc_clk,
    input  logic       func_rst_n,
    input  logic       req_valid,
    input  logic       req_sel,
    output logic       req_ready,
    output logic       done,
    output logic       busy,
    output logic       clkmux_sel,
    output logic       pll_cg_en,
    output logic       osc_cg_en,
    output logic       sys_cg_en,
    output logic [1:0] dbg_state
);

    if ((GATE_CYC < 1) || (GATE_CYC > 255)) begin : g_gate_chk
        $error("clk_switch_ctrl: GATE_CYC must be in 1..255");
    end
    if ((SW_CYC < 1) || (SW_CYC > 255)) begin : g_sw_chk
        $error("clk_switch_ctrl: SW_CYC must be in 1..255");
    end

    localparam logic [CNT_W-1:0] GATE_LD = CNT_W'(GATE_CYC - 1);
    localparam logic [CNT_W-1:0] SW_LD   = CNT_W'(SW_CYC - 1);

    clk_sw_state_t    r_state, w_nxt_state;
    logic             r_tgt_sel, w_nxt_tgt_sel;
    logic             r_clkmux_sel, w_nxt_clkmux_sel;
    logic             r_sys_cg_en, w_nxt_sys_cg_en;
    logic             w_cnt_load;
    logic [CNT_W-1:0] w_cnt_val;
    logic             w_cnt_dec;
    logic             w_cnt_zero;
`ifdef CLK_SW_AUTO_GATE_EN
    logic             r_pll_cg_en, w_nxt_pll_cg_en;
    logic             r_osc_cg_en, w_nxt_osc_cg_en;
`endif

    clk_sw_dly_cnt u_dly_cnt (
        .i_clk      (osc_clk),
        .i_rst_n    (func_rst_n),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    // State and output registers. Reset restores the safe clock configuration
    // even when it arrives in the middle of a sequence.
    always_ff @(posedge osc_clk) begin
        if (!func_rst_n) begin
            r_state      <= IDLE;
            r_tgt_sel    <= SEL_PLL;
            r_clkmux_sel <= SEL_PLL;
            r_sys_cg_en  <= 1'b1;
`ifdef CLK_SW_AUTO_GATE_EN
            r_pll_cg_en  <= 1'b1;
            r_osc_cg_en  <= 1'b1;
`endif
        end else begin
            r_state      <= w_nxt_state;
            r_tgt_sel    <= w_nxt_tgt_sel;
            r_clkmux_sel <= w_nxt_clkmux_sel;
            r_sys_cg_en  <= w_nxt_sys_cg_en;
`ifdef CLK_SW_AUTO_GATE_EN
            r_pll_cg_en  <= w_nxt_pll_cg_en;
            r_osc_cg_en  <= w_nxt_osc_cg_en;
`endif
        end
    end

    // Next-state logic, next-output logic, and delay-counter control.
    always_comb begin
        w_nxt_state      = r_state;
        w_nxt_tgt_sel    = r_tgt_sel;
        w_nxt_clkmux_sel = r_clkmux_sel;
        w_nxt_sys_cg_en  = r_sys_cg_en;
        w_cnt_load       = 1'b0;
        w_cnt_val        = GATE_LD;
        w_cnt_dec        = 1'b0;
`ifdef CLK_SW_AUTO_GATE_EN
        w_nxt_pll_cg_en  = r_pll_cg_en;
        w_nxt_osc_cg_en  = r_osc_cg_en;
`endif
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_nxt_tgt_sel = req_sel;
                    if (req_sel == r_clkmux_sel) begin
                        w_nxt_state = DONE;
                    end else begin
                        w_nxt_state     = OFF_WAIT;
                        w_nxt_sys_cg_en = 1'b0;
                        w_cnt_load      = 1'b1;
                        w_cnt_val       = GATE_LD;
`ifdef CLK_SW_AUTO_GATE_EN
                        if (req_sel == SEL_OSC) begin
                            w_nxt_osc_cg_en = 1'b1;
                        end else begin
                            w_nxt_pll_cg_en = 1'b1;
                        end
`endif
                    end
                end
            end
            OFF_WAIT: begin
                if (w_cnt_zero) begin
                    w_nxt_clkmux_sel = r_tgt_sel;
                    w_cnt_load       = 1'b1;
                    w_cnt_val        = SW_LD;
                    w_nxt_state      = SW_WAIT;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            SW_WAIT: begin
                if (w_cnt_zero) begin
                    w_nxt_sys_cg_en = 1'b1;
                    w_nxt_state     = DONE;
`ifdef CLK_SW_AUTO_GATE_EN
                    if (r_tgt_sel == SEL_OSC) begin
                        w_nxt_pll_cg_en = 1'b0;
                    end else begin
                        w_nxt_osc_cg_en = 1'b0;
                    end
`endif
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            DONE: begin
                w_nxt_state = IDLE;
            end
            default: begin
                w_nxt_state = IDLE;
            end
        endcase
    end

    assign req_ready  = (r_state == IDLE);
    assign busy       = (r_state != IDLE);
    assign done       = (r_state == DONE);
    assign clkmux_sel = r_clkmux_sel;
    assign sys_cg_en  = r_sys_cg_en;
    assign dbg_state  = r_state;
`ifdef CLK_SW_AUTO_GATE_EN
    assign pll_cg_en  = r_pll_cg_en;
    assign osc_cg_en  = r_osc_cg_en;
`else
    assign pll_cg_en  = 1'b1;
    assign osc_cg_en  = 1'b1;
`endif

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Directed bench for clk_switch_ctrl with default GATE_CYC=4 and SW_CYC=8.
module tb_clk_switch_ctrl;
  import clk_switch_pkg::*;

  localparam int G = 4;
  localparam int S = 8;
`ifdef CLK_SW_AUTO_GATE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic osc_clk = 1'b0;
  logic func_rst_n = 1'b0;
  logic req_valid = 1'b0;
  logic req_sel = 1'b0;
  logic req_ready, done, busy, clkmux_sel, pll_cg_en, osc_cg_en, sys_cg_en;
  logic [1:0] dbg_state;

  always #5 osc_clk = ~osc_clk;

  clk_switch_ctrl #(.GATE_CYC(G), .SW_CYC(S)) dut (
    .osc_clk    (osc_clk),
    .func_rst_n (func_rst_n),
    .req_valid  (req_valid),
    .req_sel    (req_sel),
    .req_ready  (req_ready),
    .done       (done),
    .busy       (busy),
    .clkmux_sel (clkmux_sel),
    .pll_cg_en  (pll_cg_en),
    .osc_cg_en  (osc_cg_en),
    .sys_cg_en  (sys_cg_en),
    .dbg_state  (dbg_state)
  );

  int checks = 0;
  int failures = 0;

  // Reference state of the clock tree controls.
  logic mdl_mux = 1'b0;
  logic mdl_pll = 1'b1;
  logic mdl_osc = 1'b1;

  // Scoreboard: expected mux select at each done pulse.
  logic [0:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge osc_clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_ready"}, req_ready, 1);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_state"}, dbg_state, IDLE);
    check_eq({tag, "_mux"}, clkmux_sel, mdl_mux);
    check_eq({tag, "_sys"}, sys_cg_en, 1);
    check_eq({tag, "_pll"}, pll_cg_en, mdl_pll);
    check_eq({tag, "_osc"}, osc_cg_en, mdl_osc);
  endtask

  task automatic do_req(input logic sel, input int poke_at, input logic poke_sel,
                        input int abort_at, input string tag);
    int total;
    logic [1:0] exp_st;
    total = G + S;
    req_valid = 1'b1;
    req_sel = sel;
    exp_q.push_back(sel);
    if (sel == mdl_mux) begin
      tick();
      req_valid = 1'b0;
      check_eq({tag, "_same_done"}, done, 1);
      check_eq({tag, "_same_state"}, dbg_state, DONE);
      check_eq({tag, "_same_busy"}, busy, 1);
      check_eq({tag, "_same_ready"}, req_ready, 0);
      check_eq({tag, "_same_mux"}, clkmux_sel, mdl_mux);
      check_eq({tag, "_same_sys"}, sys_cg_en, 1);
      tick();
      check_idle({tag, "_same_end"});
      return;
    end
    if (AUTO) begin
      if (sel) mdl_osc = 1'b1;
      else mdl_pll = 1'b1;
    end
    for (int k = 0; k <= total; k++) begin
      tick();
      req_valid = 1'b0;
      if (k >= G) mdl_mux = sel;
      if (AUTO && k == total) begin
        if (sel) mdl_pll = 1'b0;
        else mdl_osc = 1'b0;
      end
      if (k < G) exp_st = OFF_WAIT;
      else if (k < total) exp_st = SW_WAIT;
      else exp_st = DONE;
      check_eq($sformatf("%s_k%0d_sys", tag, k), sys_cg_en, (k == total) ? 1 : 0);
      check_eq($sformatf("%s_k%0d_mux", tag, k), clkmux_sel, mdl_mux);
      check_eq($sformatf("%s_k%0d_done", tag, k), done, (k == total) ? 1 : 0);
      check_eq($sformatf("%s_k%0d_ready", tag, k), req_ready, 0);
      check_eq($sformatf("%s_k%0d_busy", tag, k), busy, 1);
      check_eq($sformatf("%s_k%0d_state", tag, k), dbg_state, exp_st);
      check_eq($sformatf("%s_k%0d_pll", tag, k), pll_cg_en, mdl_pll);
      check_eq($sformatf("%s_k%0d_osc", tag, k), osc_cg_en, mdl_osc);
      if (k == poke_at) begin
        req_valid = 1'b1;
        req_sel = poke_sel;
      end
      if (k == abort_at) begin
        func_rst_n = 1'b0;
        exp_q.delete();
        tick();
        func_rst_n = 1'b1;
        mdl_mux = 1'b0;
        mdl_pll = 1'b1;
        mdl_osc = 1'b1;
        check_idle({tag, "_abort"});
        return;
      end
    end
    tick();
    check_idle({tag, "_end"});
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge osc_clk) begin
    if (func_rst_n && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_spurious_done", 1, 0);
      end else begin
        check_eq("sb_done_mux", clkmux_sel, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    func_rst_n = 1'b0;
    repeat (3) tick();
    check_idle("rst_hold");
    func_rst_n = 1'b1;
    tick();
    check_idle("rst_rel");

    // Same source: PLL requested while PLL selected.
    do_req(1'b0, -1, 1'b0, -1, "same_pll");
    // PLL -> OSC with an ignored request poked during OFF_WAIT.
    do_req(1'b1, 1, 1'b0, -1, "to_osc");
    // Back-to-back: request PLL on the first ready edge.
    do_req(1'b0, -1, 1'b0, -1, "b2b_pll");
    // Reset one cycle after the mux flip.
    do_req(1'b1, -1, 1'b0, G + 1, "abort");
    repeat (3) begin
      tick();
      check_eq("post_abort_done", done, 0);
    end
    // Recover with a normal switch after the abort.
    do_req(1'b1, -1, 1'b0, -1, "recover_osc");
    do_req(1'b1, -1, 1'b0, -1, "same_osc");

    check_eq("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
